// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline and its sequencer (pipe_ctrl).
// master: pipeline side (raises requests, consumes stall/flush).
// slave:  pipe_ctrl.
// Optional macro PIPE_MDU_WDOG_EN adds the mdu_timeout signal.
`timescale 1ns/1ps

interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        mdu_start;
  logic        mdu_done;
  logic        excp_valid;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mdu_cancel;
  logic        mdu_busy;
`ifdef PIPE_MDU_WDOG_EN
  logic        mdu_timeout;

  modport master (
    output stallreq_id, stallreq_ex, mdu_start, mdu_done, excp_valid, excp_pc,
    input  stall, flush, new_pc, mdu_cancel, mdu_busy, mdu_timeout
  );

  modport slave (
    input  stallreq_id, stallreq_ex, mdu_start, mdu_done, excp_valid, excp_pc,
    output stall, flush, new_pc, mdu_cancel, mdu_busy, mdu_timeout
  );
`else
  modport master (
    output stallreq_id, stallreq_ex, mdu_start, mdu_done, excp_valid, excp_pc,
    input  stall, flush, new_pc, mdu_cancel, mdu_busy
  );

  modport slave (
    input  stallreq_id, stallreq_ex, mdu_start, mdu_done, excp_valid, excp_pc,
    output stall, flush, new_pc, mdu_cancel, mdu_busy
  );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges ID/EX stall requests, sequences multi-cycle
// MDU ops through a start/done handshake and runs the exception flush.
// stall bits: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1 = stop.
// Optional macro PIPE_MDU_WDOG_EN enables the MDU_WAIT watchdog and mdu_timeout.
`timescale 1ns/1ps

module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned MDU_MAX_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input logic         clk,
  input logic         rst_n,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMduWait = 2'd1,
    StFlush   = 2'd2
  } state_e;

  localparam logic [5:0] StallAll = 6'b111111;
  localparam logic [5:0] StallEx  = 6'b001111;
  localparam logic [5:0] StallId  = 6'b000111;

  localparam logic [CNT_W-1:0] FlushLast = CNT_W'(FLUSH_CYCLES - 1);
`ifdef PIPE_MDU_WDOG_EN
  localparam logic [CNT_W-1:0] MduLast   = CNT_W'(MDU_MAX_CYCLES - 1);
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [5:0]        stall_c;
  logic              cancel_c;
  logic              timeout_c;

  // Saturating increment shared by the MDU wait and flush counts.
  always_comb begin
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  // Next-state, counter, PC latch and combinational stall/cancel decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    new_pc_d  = new_pc_q;
    stall_c   = '0;
    cancel_c  = 1'b0;
    timeout_c = 1'b0;

    unique case (state_q)
      StRun: begin
        if (bus.excp_valid) begin
          stall_c  = StallAll;
          new_pc_d = bus.excp_pc;
          cnt_d    = '0;
          state_d  = StFlush;
        end else if (bus.mdu_start && !bus.mdu_done) begin
          stall_c = StallEx;
          cnt_d   = '0;
          state_d = StMduWait;
        end else begin
          // A single-cycle MDU op adds no stall, but ID/EX hazards still apply.
          if (bus.stallreq_ex) begin
            stall_c = StallEx;
          end else if (bus.stallreq_id) begin
            stall_c = StallId;
          end
        end
      end

      StMduWait: begin
        if (bus.excp_valid) begin
          stall_c  = StallAll;
          cancel_c = 1'b1;
          new_pc_d = bus.excp_pc;
          cnt_d    = '0;
          state_d  = StFlush;
        end else if (bus.mdu_done) begin
          // EX takes the result this cycle, so nothing stops.
          state_d = StRun;
`ifdef PIPE_MDU_WDOG_EN
        end else if (cnt_q == MduLast) begin
          stall_c   = StallEx;
          cancel_c  = 1'b1;
          timeout_c = 1'b1;
          state_d   = StRun;
`endif
        end else begin
          stall_c = StallEx;
          cnt_d   = cnt_inc;
        end
      end

      StFlush: begin
        cnt_d = cnt_inc;
        if (cnt_q == FlushLast) begin
          state_d = StRun;
        end
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State, counter and redirect PC registers; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Outputs; the combinational ones are forced quiet while reset is held.
  always_comb begin
    bus.stall       = rst_n ? stall_c : 6'b000000;
    bus.mdu_cancel  = rst_n & cancel_c;
    bus.flush       = (state_q == StFlush);
    bus.mdu_busy    = (state_q == StMduWait);
    bus.new_pc      = new_pc_q;
`ifdef PIPE_MDU_WDOG_EN
    bus.mdu_timeout = rst_n & timeout_c;
`endif
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written
// reset/watchdog sequences, then randomized traffic against a reference model.
// Honours PIPE_MDU_WDOG_EN when defined.
`timescale 1ns/1ps

module tb_pipe_ctrl;

  localparam int unsigned FC = 2;
  localparam int unsigned MM = 8;
`ifdef PIPE_MDU_WDOG_EN
  localparam bit Wdog = 1'b1;
`else
  localparam bit Wdog = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .FLUSH_CYCLES   (FC),
    .MDU_MAX_CYCLES (MM),
    .CNT_W          (7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic        ex;
    logic        start;
    logic        done;
    logic        excp;
    logic [31:0] pc;
    logic [5:0]  stall;
    logic        flush;
    logic        busy;
    logic        cancel;
    logic [31:0] npc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic id, input logic ex, input logic start,
                              input logic done, input logic excp, input logic [31:0] pc,
                              input logic [5:0] stall, input logic flush, input logic busy,
                              input logic cancel, input logic [31:0] npc);
    vec_t v;
    v.id = id; v.ex = ex; v.start = start; v.done = done; v.excp = excp; v.pc = pc;
    v.stall = stall; v.flush = flush; v.busy = busy; v.cancel = cancel; v.npc = npc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic ex, input logic start, input logic done,
                       input logic excp, input logic [31:0] pc);
    bus.stallreq_id = id;
    bus.stallreq_ex = ex;
    bus.mdu_start   = start;
    bus.mdu_done    = done;
    bus.excp_valid  = excp;
    bus.excp_pc     = pc;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reference model state: outstanding MDU op, cycles already waited,
    // flush cycles still to run and the latched handler address.
    bit          m_wait;
    int          m_waited;
    int          m_flush_left;
    logic [31:0] m_pc;

    localparam logic [31:0] Z = 32'h0;
    localparam logic [31:0] H = 32'hBFC0_0380;
    localparam logic [31:0] H2 = 32'h0000_1234;
    localparam logic [31:0] H3 = 32'h8000_0180;

    // ---------------- reset state, stall requests masked during reset ----------
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    #2;
    chk("reset_stall", 32'(bus.stall), 32'h0);
    chk("reset_flush", 32'(bus.flush), 32'h0);
    chk("reset_new_pc", bus.new_pc, 32'h0);
    chk("reset_cancel", 32'(bus.mdu_cancel), 32'h0);
    chk("reset_busy", 32'(bus.mdu_busy), 32'h0);
    do_reset();

    // ---------------- directed vector table ----------------
    //             id ex st dn ex  pc   stall       fl bs cn npc
    vecs.push_back(mk(0, 0, 0, 0, 0, Z,  6'b000000, 0, 0, 0, Z));
    vecs.push_back(mk(1, 0, 0, 0, 0, Z,  6'b000111, 0, 0, 0, Z));  // load-use
    vecs.push_back(mk(0, 0, 0, 0, 0, Z,  6'b000000, 0, 0, 0, Z));
    vecs.push_back(mk(1, 1, 0, 0, 0, Z,  6'b001111, 0, 0, 0, Z));  // EX wins
    vecs.push_back(mk(0, 1, 0, 0, 0, Z,  6'b001111, 0, 0, 0, Z));
    vecs.push_back(mk(0, 0, 1, 1, 0, Z,  6'b000000, 0, 0, 0, Z));  // 1-cycle MDU
    vecs.push_back(mk(1, 0, 1, 0, 0, Z,  6'b001111, 0, 0, 0, Z));  // T0 start
    vecs.push_back(mk(1, 1, 0, 0, 0, Z,  6'b001111, 0, 1, 0, Z));  // T1
    vecs.push_back(mk(0, 0, 1, 0, 0, Z,  6'b001111, 0, 1, 0, Z));  // T2
    vecs.push_back(mk(0, 0, 0, 0, 0, Z,  6'b001111, 0, 1, 0, Z));  // T3
    vecs.push_back(mk(0, 0, 0, 0, 0, Z,  6'b001111, 0, 1, 0, Z));  // T4
    vecs.push_back(mk(0, 0, 0, 1, 0, Z,  6'b000000, 0, 1, 0, Z));  // T5 done
    vecs.push_back(mk(0, 0, 0, 0, 0, Z,  6'b000000, 0, 0, 0, Z));  // back in RUN
    vecs.push_back(mk(1, 0, 0, 0, 1, H,  6'b111111, 0, 0, 0, Z));  // T0 exception
    vecs.push_back(mk(1, 1, 1, 1, 1, H2, 6'b000000, 1, 0, 0, H));  // T1 flush
    vecs.push_back(mk(0, 1, 0, 0, 0, Z,  6'b000000, 1, 0, 0, H));  // T2 flush
    vecs.push_back(mk(1, 0, 0, 0, 0, Z,  6'b000111, 0, 0, 0, H));  // T3 RUN
    vecs.push_back(mk(0, 0, 1, 0, 0, Z,  6'b001111, 0, 0, 0, H));  // start
    vecs.push_back(mk(1, 1, 0, 0, 0, Z,  6'b001111, 0, 1, 0, H));
    vecs.push_back(mk(0, 0, 0, 0, 1, H2, 6'b111111, 0, 1, 1, H));  // excp in wait
    vecs.push_back(mk(0, 0, 0, 1, 0, Z,  6'b000000, 1, 0, 0, H2)); // done ignored
    vecs.push_back(mk(0, 0, 0, 1, 0, Z,  6'b000000, 1, 0, 0, H2));
    vecs.push_back(mk(0, 0, 0, 0, 0, Z,  6'b000000, 0, 0, 0, H2));
    vecs.push_back(mk(0, 0, 1, 0, 0, Z,  6'b001111, 0, 0, 0, H2)); // start
    vecs.push_back(mk(0, 0, 0, 1, 1, H3, 6'b111111, 0, 1, 1, H2)); // excp beats done
    vecs.push_back(mk(0, 0, 0, 0, 0, Z,  6'b000000, 1, 0, 0, H3));
    vecs.push_back(mk(0, 0, 0, 0, 0, Z,  6'b000000, 1, 0, 0, H3));
    vecs.push_back(mk(0, 0, 0, 0, 0, Z,  6'b000000, 0, 0, 0, H3));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].id, vecs[i].ex, vecs[i].start, vecs[i].done, vecs[i].excp, vecs[i].pc);
      #2;
      chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(vecs[i].stall));
      chk($sformatf("vec%0d_flush", i), 32'(bus.flush), 32'(vecs[i].flush));
      chk($sformatf("vec%0d_busy", i), 32'(bus.mdu_busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_cancel", i), 32'(bus.mdu_cancel), 32'(vecs[i].cancel));
      if (vecs[i].flush) chk($sformatf("vec%0d_new_pc", i), bus.new_pc, vecs[i].npc);
      tick();
    end

    // ---------------- async reset mid-MDU_WAIT ----------------
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, Z);
    #2;
    chk("mdu_wait_busy", 32'(bus.mdu_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mdu_stall", 32'(bus.stall), 32'h0);
    chk("rst_mid_mdu_busy", 32'(bus.mdu_busy), 32'h0);
    do_reset();

    // ---------------- async reset mid-FLUSH ----------------
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, H);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z);
    #2;
    chk("flush_before_rst", 32'(bus.flush), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_flush_flush", 32'(bus.flush), 32'h0);
    chk("rst_mid_flush_new_pc", bus.new_pc, 32'h0);
    do_reset();

`ifdef PIPE_MDU_WDOG_EN
    // ---------------- watchdog: no mdu_done after start ----------------
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z);
    #2;
    chk("wd_t0_timeout", 32'(bus.mdu_timeout), 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z);
    for (int k = 1; k <= int'(MM); k++) begin
      #2;
      chk($sformatf("wd_t%0d_timeout", k), 32'(bus.mdu_timeout), 32'(k == int'(MM)));
      chk($sformatf("wd_t%0d_cancel", k), 32'(bus.mdu_cancel), 32'(k == int'(MM)));
      chk($sformatf("wd_t%0d_stall", k), 32'(bus.stall), 32'h0f);
      tick();
    end
    #2;
    chk("wd_after_busy", 32'(bus.mdu_busy), 32'h0);
    chk("wd_after_stall", 32'(bus.stall), 32'h0);
    do_reset();
`endif

    // ---------------- randomized traffic vs reference model ----------------
    m_wait = 1'b0;
    m_waited = 0;
    m_flush_left = 0;
    m_pc = 32'h0;
    for (int c = 0; c < 800; c++) begin
      logic id, ex, st, dn, ev;
      logic [31:0] pc;
      int depth;
      bit e_cancel, e_timeout;
      logic [5:0] e_stall;
      id = ($urandom_range(0, 3) == 0);
      ex = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 2) == 0);
      dn = ($urandom_range(0, 4) == 0);
      ev = ($urandom_range(0, 29) == 0);
      pc = $urandom;
      e_cancel = 1'b0;
      e_timeout = 1'b0;
      if (m_flush_left > 0) depth = 0;
      else if (ev) begin depth = 6; e_cancel = m_wait; end
      else if (m_wait) begin
        if (dn) depth = 0;
        else if (Wdog && m_waited == int'(MM) - 1) begin
          depth = 4; e_cancel = 1'b1; e_timeout = 1'b1;
        end else depth = 4;
      end
      else if (st && !dn) depth = 4;
      else if (ex) depth = 4;
      else if (id) depth = 3;
      else depth = 0;
      e_stall = 6'((1 << depth) - 1);

      drive(id, ex, st, dn, ev, pc);
      #2;
      chk($sformatf("rnd%0d_stall", c), 32'(bus.stall), 32'(e_stall));
      chk($sformatf("rnd%0d_flush", c), 32'(bus.flush), 32'(m_flush_left > 0));
      chk($sformatf("rnd%0d_busy", c), 32'(bus.mdu_busy), 32'(m_wait));
      chk($sformatf("rnd%0d_cancel", c), 32'(bus.mdu_cancel), 32'(e_cancel));
`ifdef PIPE_MDU_WDOG_EN
      chk($sformatf("rnd%0d_timeout", c), 32'(bus.mdu_timeout), 32'(e_timeout));
`endif
      if (m_flush_left > 0) chk($sformatf("rnd%0d_new_pc", c), bus.new_pc, m_pc);

      if (m_flush_left > 0) m_flush_left--;
      else if (ev) begin m_flush_left = int'(FC); m_pc = pc; m_wait = 1'b0; end
      else if (m_wait) begin
        if (dn || e_timeout) m_wait = 1'b0;
        else m_waited++;
      end
      else if (st && !dn) begin m_wait = 1'b1; m_waited = 0; end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
